// File: rtl/sha256_pkg.sv
// Shared types, round constants and message-schedule sigma functions for the SHA-256 round controller.
package sha256_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned WIN_DEPTH = 16;
    localparam int unsigned WCNT_W    = 4;
    localparam int unsigned RCNT_W    = 6;
    localparam int unsigned N_ROUNDS  = 64;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] K [N_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational lookup of the SHA-256 round constant for a 6-bit round index.
import sha256_pkg::*;

module sha256_k_rom (
    input  logic [5:0]  idx,
    output logic [31:0] k_c
);

    assign k_c = K[idx];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round controller: buffers 16-word chunks, expands the message schedule and sequences the compress datapath.
// Optional chunk performance counter enabled by defining SHA256_PERF_CNT_EN.
import sha256_pkg::*;

module sha256_round_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              proc_start,
    output logic              update_hash,
    output logic [31:0]       w_in,
    output logic [31:0]       k_in,
    output logic              core_init,
    output logic              busy,
    output logic              done
`ifdef SHA256_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  chunk_cnt
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic [WCNT_W-1:0]   word_cnt;
    logic [RCNT_W-1:0]   rnd;
    logic [WORD_W-1:0]   window [WIN_DEPTH];
    logic [WORD_W-1:0]   sched_nxt;
    logic [WORD_W-1:0]   k_c;
    logic                new_msg;
    logic                last_flag;
    logic                accept;

    assign accept    = s_valid & s_ready;
    assign sched_nxt = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];

    sha256_k_rom u_k_rom (
        .idx (rnd),
        .k_c (k_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_LOAD:   if (accept && word_cnt == WCNT_W'(WIN_DEPTH - 1)) state_nxt = ST_RUN;
            ST_RUN:    if (rnd == RCNT_W'(N_ROUNDS - 1)) state_nxt = ST_UPDATE;
            ST_UPDATE: state_nxt = ST_LOAD;
            default:   state_nxt = ST_LOAD;
        endcase
    end

    // Output decode; everything held low while reset is asserted
    always_comb begin
        s_ready     = 1'b0;
        proc_start  = 1'b0;
        update_hash = 1'b0;
        busy        = 1'b0;
        w_in        = '0;
        k_in        = '0;
        if (!rst) begin
            unique case (state)
                ST_LOAD: s_ready = 1'b1;
                ST_RUN: begin
                    proc_start = 1'b1;
                    busy       = 1'b1;
                    w_in       = window[0];
                    k_in       = k_c;
                end
                ST_UPDATE: begin
                    proc_start  = 1'b1;
                    update_hash = 1'b1;
                    busy        = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Word window, counters and message-boundary tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt  <= '0;
            rnd       <= '0;
            new_msg   <= 1'b1;
            last_flag <= 1'b0;
            core_init <= 1'b0;
            done      <= 1'b0;
            window    <= '{default: '0};
        end else begin
            core_init <= accept && (word_cnt == '0) && new_msg;
            done      <= (state == ST_UPDATE) && last_flag;

            if (accept) begin
                window[word_cnt] <= s_data;
                word_cnt         <= word_cnt + WCNT_W'(1);
                if (word_cnt == '0) new_msg <= 1'b0;
                if (word_cnt == WCNT_W'(WIN_DEPTH - 1)) last_flag <= s_last;
            end

            // Window slides by one word per round; rnd wraps to 0 after round 63
            if (state == ST_RUN) begin
                for (int i = 0; i < int'(WIN_DEPTH) - 1; i++) begin
                    window[i] <= window[i+1];
                end
                window[WIN_DEPTH-1] <= sched_nxt;
                rnd                 <= rnd + RCNT_W'(1);
            end

            if (state == ST_UPDATE && last_flag) new_msg <= 1'b1;
        end
    end

`ifdef SHA256_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chunk_cnt <= '0;
        end else if (state == ST_UPDATE) begin
            chunk_cnt <= chunk_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: a behavioural compress datapath follows the controller outputs
// and completed digests are scored against a queue of expected values.
module tb_sha256_round_ctrl;

    localparam int unsigned CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [31:0]       s_data = '0;
    logic              s_last = 1'b0;
    logic              proc_start;
    logic              update_hash;
    logic [31:0]       w_in;
    logic [31:0]       k_in;
    logic              core_init;
    logic              busy;
    logic              done;
`ifdef SHA256_PERF_CNT_EN
    logic [CNT_W-1:0]  chunk_cnt;
`endif

    sha256_round_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .proc_start  (proc_start),
        .update_hash (update_hash),
        .w_in        (w_in),
        .k_in        (k_in),
        .core_init   (core_init),
        .busy        (busy),
        .done        (done)
`ifdef SHA256_PERF_CNT_EN
        ,
        .chunk_cnt   (chunk_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference compress datapath ----------------
    localparam logic [255:0] IV_ALL  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic [31:0]  hs [8];
    logic [31:0]  wv [8];
    logic [255:0] exp_q [$];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] digest_now();
        return {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]};
    endfunction

    task automatic load_iv();
        logic [255:0] iv;
        iv = IV_ALL;
        for (int i = 0; i < 8; i++) hs[i] = iv[255 - 32*i -: 32];
    endtask

    task automatic round_step(input logic [31:0] w, input logic [31:0] k);
        logic [31:0] t1, t2;
        t1 = wv[7] + (rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25))
           + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + k + w;
        t2 = (rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22))
           + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
        for (int i = 7; i > 0; i--) wv[i] = wv[i-1];
        wv[4] = wv[4] + t1;
        wv[0] = t1 + t2;
    endtask

    // ---------------- monitor (samples at negedge) ----------------
    int cyc = 0;
    int tb_wcnt = 0;
    int rnd_tb = -1;
    bit prev_ps = 1'b0;
    int w0_cyc = -1, acc15_cyc = -1, run_cyc = -1, upd_cyc = -1, done_cyc = -1, ci_cyc = -1;
    int n_core_init = 0, n_done = 0, n_accept = 0, n_ready_busy = 0, n_out_idle = 0;
    logic [31:0] k_t0 = '0, k_t63 = '0, w_t16 = '0;

    always @(negedge clk) begin
        if (rst) begin
            load_iv();
            prev_ps = 1'b0;
            tb_wcnt = 0;
            rnd_tb  = -1;
        end else begin
            if (core_init) begin
                load_iv();
                n_core_init++;
                ci_cyc = cyc;
            end else if (update_hash) begin
                for (int i = 0; i < 8; i++) hs[i] = hs[i] + wv[i];
                upd_cyc = cyc;
            end else if (proc_start) begin
                if (!prev_ps) begin
                    for (int i = 0; i < 8; i++) wv[i] = hs[i];
                    rnd_tb  = 0;
                    run_cyc = cyc;
                end else begin
                    rnd_tb++;
                end
                if (rnd_tb == 0)  k_t0  = k_in;
                if (rnd_tb == 63) k_t63 = k_in;
                if (rnd_tb == 16) w_t16 = w_in;
                round_step(w_in, k_in);
            end
            prev_ps = proc_start;
            if (s_ready && busy) n_ready_busy++;
            if (!proc_start && (w_in != '0 || k_in != '0)) n_out_idle++;
            if (s_valid && s_ready) begin
                n_accept++;
                if (tb_wcnt == 0)  w0_cyc    = cyc;
                if (tb_wcnt == 15) acc15_cyc = cyc;
                tb_wcnt = (tb_wcnt + 1) % 16;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (exp_q.size() == 0) check_eq("unexpected_done", 256'(1), 256'(0));
                else                   check_eq("digest", digest_now(), exp_q.pop_front());
            end
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input int gap_max);
        int gaps;
        int b;
        gaps = (gap_max > 0) ? int'($urandom_range(0, 32'(gap_max))) : 0;
        repeat (gaps) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        b = 200;
        while (!s_ready && b > 0) begin
            tick();
            b--;
        end
        if (b == 0) check_eq("ready_timeout", 256'(s_ready), 256'(1));
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_chunk(input logic [31:0] w [16], input logic last, input int gap_max, input bit rand_last);
        logic l;
        for (int i = 0; i < 16; i++) begin
            if (i == 15)        l = last;
            else if (rand_last) l = 1'($urandom_range(0, 1));
            else                l = 1'b0;
            send_word(w[i], l, gap_max);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int b;
        b = budget;
        while (!done && b > 0) begin
            tick();
            b--;
        end
        check_eq(tag, 256'(done), 256'(1));
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] abc_w [16];
    logic [31:0] c1_w  [16];
    logic [31:0] c2_w  [16];
    int base_done, base_ci, base_acc;

    initial begin
        for (int i = 0; i < 16; i++) begin
            abc_w[i] = '0;
            c2_w[i]  = '0;
        end
        abc_w[0]  = 32'h61626380;
        abc_w[15] = 32'h00000018;
        for (int i = 0; i < 14; i++) begin
            c1_w[i] = {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)};
        end
        c1_w[14] = 32'h80000000;
        c1_w[15] = 32'h00000000;
        c2_w[15] = 32'h000001c0;

        // Reset state
        repeat (3) tick();
        check_eq("rst_ctrl_outs", 256'({s_ready, proc_start, update_hash, busy, done, core_init}), 256'(0));
        check_eq("rst_data_outs", 256'({w_in, k_in}), 256'(0));
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", 256'(s_ready), 256'(1));

        // "abc", back-to-back words, s_valid held high through RUN
        exp_q.push_back(DIG_ABC);
        send_chunk(abc_w, 1'b1, 0, 1'b0);
        s_valid = 1'b1;
        s_data  = 32'hdeadbeef;
        s_last  = 1'b1;
        wait_done("abc_done_seen", 100);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_eq("ready_with_done", 256'(s_ready), 256'(1));
        tick();
        check_eq("b2b_word_span", 256'(acc15_cyc - w0_cyc), 256'(15));
        check_eq("core_init_lat", 256'(ci_cyc - w0_cyc), 256'(1));
        check_eq("run_lat", 256'(run_cyc - acc15_cyc), 256'(1));
        check_eq("update_lat", 256'(upd_cyc - acc15_cyc), 256'(65));
        check_eq("done_lat", 256'(done_cyc - acc15_cyc), 256'(66));
        check_eq("k_t0", 256'(k_t0), 256'(32'h428a2f98));
        check_eq("k_t63", 256'(k_t63), 256'(32'hc67178f2));
        check_eq("w_t16", 256'(w_t16), 256'(32'h61626380));
        check_eq("abc_words_taken", 256'(n_accept), 256'(16));

        // Two-chunk message with random gaps and stray s_last on words 0-14
        base_done = n_done;
        base_ci   = n_core_init;
        base_acc  = n_accept;
        exp_q.push_back(DIG_TWO);
        send_chunk(c1_w, 1'b0, 3, 1'b1);
        send_chunk(c2_w, 1'b1, 3, 1'b1);
        wait_done("two_done_seen", 100);
        tick();
        check_eq("two_core_init", 256'(n_core_init - base_ci), 256'(1));
        check_eq("two_done_cnt", 256'(n_done - base_done), 256'(1));
        check_eq("two_words_taken", 256'(n_accept - base_acc), 256'(32));
`ifdef SHA256_PERF_CNT_EN
        check_eq("chunk_cnt", 256'(chunk_cnt), 256'(3));
`endif

        // Reset around round 30, then a fresh "abc"
        base_done = n_done;
        send_chunk(abc_w, 1'b1, 0, 1'b0);
        begin
            int b;
            b = 100;
            while (rnd_tb != 30 && b > 0) begin
                tick();
                b--;
            end
            check_eq("reached_round30", 256'(rnd_tb), 256'(30));
        end
        rst = 1'b1;
        tick();
        check_eq("midrun_rst_outs", 256'({s_ready, proc_start, busy, done}), 256'(0));
        rst = 1'b0;
        repeat (80) tick();
        check_eq("aborted_no_done", 256'(n_done - base_done), 256'(0));
        exp_q.push_back(DIG_ABC);
        send_chunk(abc_w, 1'b1, 2, 1'b0);
        wait_done("abc2_done_seen", 100);
        tick();
        check_eq("abc2_done_cnt", 256'(n_done - base_done), 256'(1));

        check_eq("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        check_eq("ready_while_busy", 256'(n_ready_busy), 256'(0));
        check_eq("w_k_idle_zero", 256'(n_out_idle), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
